// File: rtl/led_trail_fader.sv
// PWM "comet tail" post-processor for the LED pattern: lit LEDs are solid on, and once
// released each LED fades out over several PWM frames.
`timescale 1ns/1ps
module led_trail_fader #(
   parameter int unsigned PWM_BITS   = 4,
   parameter int unsigned DECAY_SLOW = 8,
   parameter int unsigned DECAY_FAST = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] led_in,
   input  logic       fade_en,
   input  logic       decay_sel,
   output logic [7:0] led_out
);

   localparam int unsigned N_LED     = 8;
   localparam int unsigned DECAY_MAX = (DECAY_SLOW > DECAY_FAST) ? DECAY_SLOW : DECAY_FAST;
   localparam int unsigned FC_W      = $clog2(DECAY_MAX) + 1;
   localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

   logic [N_LED-1:0]    led_in_r;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [FC_W-1:0]     frame_cnt;
   logic [PWM_BITS-1:0] lvl [N_LED];

   logic                frame_end_c;
   logic                strobe_c;
   logic [FC_W-1:0]     period_m1_c;
   logic [PWM_BITS-1:0] lvl_nxt_c [N_LED];
   logic [N_LED-1:0]    led_nxt_c;

   // Decay strobe: >= lets a mid-period switch to the shorter period fire at the next frame end
   always_comb begin
      frame_end_c = (pwm_cnt == LVL_MAX);
      period_m1_c = decay_sel ? FC_W'(DECAY_FAST - 1) : FC_W'(DECAY_SLOW - 1);
      strobe_c    = frame_end_c && (frame_cnt >= period_m1_c);
   end

   // Per-LED level update (clear > reload > decay > hold) and PWM output compare
   always_comb begin
      led_nxt_c = '0;
      for (int i = 0; i < N_LED; i++) begin
         lvl_nxt_c[i] = lvl[i];
         if (!fade_en) begin
            lvl_nxt_c[i] = '0;
         end else if (led_in_r[i]) begin
            lvl_nxt_c[i] = LVL_MAX;
         end else if (strobe_c && (lvl[i] != '0)) begin
            lvl_nxt_c[i] = lvl[i] - 1'b1;
         end
         led_nxt_c[i] = led_in_r[i] | (fade_en & (lvl[i] > pwm_cnt));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_in_r  <= '0;
         pwm_cnt   <= '0;
         frame_cnt <= '0;
         led_out   <= '0;
         for (int i = 0; i < N_LED; i++) begin
            lvl[i] <= '0;
         end
      end else if (ena) begin
         led_in_r <= led_in;
         pwm_cnt  <= pwm_cnt + 1'b1;
         if (frame_end_c) begin
            frame_cnt <= strobe_c ? '0 : frame_cnt + 1'b1;
         end
         led_out <= led_nxt_c;
         for (int i = 0; i < N_LED; i++) begin
            lvl[i] <= lvl_nxt_c[i];
         end
      end
   end

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: per-cycle reference model plus table-driven pass-through
// vectors and hand-written fade, switch, reload, freeze and reset sequences.
`timescale 1ns/1ps
module tb_led_trail_fader;

   localparam int DS = 8;
   localparam int DF = 2;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       ena       = 1'b0;
   logic       fade_en   = 1'b0;
   logic       decay_sel = 1'b0;
   logic [7:0] led_in    = 8'h00;
   logic [7:0] led_out;

   int n_vec = 0;
   int n_err = 0;

   led_trail_fader #(.PWM_BITS(4), .DECAY_SLOW(DS), .DECAY_FAST(DF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .led_in    (led_in),
      .fade_en   (fade_en),
      .decay_sel (decay_sel),
      .led_out   (led_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, written from the behavioural description using integers
   int         m_pwm;
   int         m_fc;
   int         m_lvl [8];
   logic [7:0] m_lin;
   logic [7:0] m_out;
   int         m_pm1;
   logic       m_stb;

   assign m_pm1 = decay_sel ? (DF - 1) : (DS - 1);
   assign m_stb = (m_pwm == 15) && (m_fc >= m_pm1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pwm <= 0;
         m_fc  <= 0;
         m_lin <= 8'h00;
         m_out <= 8'h00;
         for (int i = 0; i < 8; i++) m_lvl[i] <= 0;
      end else if (ena) begin
         m_lin <= led_in;
         m_pwm <= (m_pwm + 1) % 16;
         if (m_pwm == 15) m_fc <= m_stb ? 0 : m_fc + 1;
         for (int i = 0; i < 8; i++) begin
            m_out[i] <= m_lin[i] | (fade_en && (m_pwm < m_lvl[i]));
            if (!fade_en)                     m_lvl[i] <= 0;
            else if (m_lin[i])                m_lvl[i] <= 15;
            else if (m_stb && m_lvl[i] > 0)   m_lvl[i] <= m_lvl[i] - 1;
         end
      end
   end

   always @(negedge clk) chk("model_led_out", 32'(led_out), 32'(m_out));

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] exp_q [$];

   task automatic do_reset();
      rst_n  = 1'b0;
      led_in = 8'h00;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin : main
      int         hi_w1, hi_w2, last_hi, cnt;
      logic [6:0] others;
      logic [7:0] ref_out;
      logic [7:0] exp_v;
      bit         found;

      vecs[0] = '{8'hA5, 8'hA5};  vecs[1] = '{8'h3C, 8'h3C};
      vecs[2] = '{8'hFF, 8'hFF};  vecs[3] = '{8'h00, 8'h00};
      vecs[4] = '{8'h81, 8'h81};  vecs[5] = '{8'h7E, 8'h7E};
      vecs[6] = '{8'h55, 8'h55};  vecs[7] = '{8'hAA, 8'hAA};
      vecs[8] = '{8'h01, 8'h01};  vecs[9] = '{8'h00, 8'h00};

      // Reset holds output low even with all LEDs requested
      ena = 1'b1; fade_en = 1'b1; led_in = 8'hFF;
      repeat (6) begin
         @(negedge clk);
         chk("reset_hold", 32'(led_out), 32'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release_1", 32'(led_out), 32'h0);
      @(negedge clk);
      chk("reset_release_2", 32'(led_out), 32'hFF);

      // Registered pass-through, two-cycle latency
      fade_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         led_in = vecs[k].din;
         exp_q.push_back(vecs[k].exp);
         @(negedge clk);
         if (exp_q.size() > 1) begin
            exp_v = exp_q.pop_front();
            chk("pass_through", 32'(led_out), 32'(exp_v));
         end
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      chk("pass_through_last", 32'(led_out), 32'(exp_v));

      // Slow tail on bit 0 from a known frame phase
      do_reset();
      fade_en = 1'b1; decay_sel = 1'b0; led_in = 8'h01;
      repeat (4) @(negedge clk);
      led_in = 8'h00;
      hi_w1 = 0; hi_w2 = 0; last_hi = -1; others = '0;
      for (int t = 1; t <= 2048; t++) begin
         @(negedge clk);
         if (led_out[0]) last_hi = t;
         others |= led_out[7:1];
         if (t >= 17  && t <= 32  && led_out[0]) hi_w1++;
         if (t >= 145 && t <= 160 && led_out[0]) hi_w2++;
      end
      chk("slow_duty_lvl15", 32'(hi_w1), 32'd15);
      chk("slow_duty_lvl14", 32'(hi_w2), 32'd14);
      chk("slow_last_high",  32'(last_hi), 32'd1901);
      chk("slow_other_bits", 32'(others), 32'h0);

      // Switch to fast decay at frame 5 of a slow period
      do_reset();
      fade_en = 1'b1; decay_sel = 1'b0; led_in = 8'h01;
      repeat (4) @(negedge clk);
      led_in = 8'h00;
      repeat (84) @(negedge clk);
      decay_sel = 1'b1;
      last_hi = -1;
      for (int j = 1; j <= 512; j++) begin
         @(negedge clk);
         if (led_out[0]) last_hi = j;
      end
      chk("fast_last_high", 32'(last_hi), 32'd441);

      // Relight bit 3 so that it is registered on the strobe cycle at level 7
      led_in = 8'h08;
      repeat (2) @(negedge clk);
      led_in = 8'h00;
      found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk);
         if (m_pwm == 14 && m_lvl[3] == 7 && m_fc >= DF - 1) found = 1'b1;
      end
      chk("reload_window_found", 32'(found), 32'd1);
      if (found) begin
         led_in = 8'h08;
         @(negedge clk);
         led_in = 8'h00;
         @(negedge clk);
         cnt = 0;
         repeat (16) begin
            @(negedge clk);
            if (led_out[3]) cnt++;
         end
         chk("reload_beats_strobe", 32'(cnt), 32'd15);
      end

      // Freeze mid-fade
      repeat (50) @(negedge clk);
      ref_out = led_out;
      ena = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k % 10 == 9) chk("freeze_hold", 32'(led_out), 32'(ref_out));
      end
      ena = 1'b1;
      repeat (200) @(negedge clk);

      // Asynchronous reset mid-fade leaves no tail
      led_in = 8'h08;
      repeat (3) @(negedge clk);
      led_in = 8'h00;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_clear", 32'(led_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (led_out != 8'h00) cnt++;
      end
      chk("no_tail_after_reset", 32'(cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
